wb_port_arbiter: RTL and testbench

Shares the single register-file write port among the three completing execution pipes: Mult, AluMisc and Mem. Each pipe pushes completed results through a valid/ready handshake into a private FIFO, so simultaneous completions are buffered rather than dropped. One result per cycle is granted and driven onto a registered write-port bus to the register file. The block sits between the pipe tails and the register file, where it replaces a purely combinational priority mux.

---
 rtl/wb_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - three-source write-back arbiter with per-source FIFOs and a registered RF write port.
// Define WB_ARB_RR_EN for round-robin grants; by default Mem > AluMisc > Mult.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mul_wb_valid,
  output logic        mul_wb_ready,
  input  logic [4:0]  mul_wb_regdest,
  input  logic        mul_wb_writereg,
  input  logic [31:0] mul_wb_wbvalue,
  input  logic        am_wb_valid,
  output logic        am_wb_ready,
  input  logic [4:0]  am_wb_regdest,
  input  logic        am_wb_writereg,
  input  logic [31:0] am_wb_wbvalue,
  input  logic        mem_wb_valid,
  output logic        mem_wb_ready,
  input  logic [4:0]  mem_wb_regdest,
  input  logic        mem_wb_writereg,
  input  logic [31:0] mem_wb_wbvalue,
  output logic        wb_reg_en,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_busy
);

  localparam int NSRC = 3;
  localparam logic [1:0] SRC_MUL = 2'd0;
  localparam logic [1:0] SRC_AM  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [NSRC-1:0] w_valid;
  logic [NSRC-1:0] w_writereg;
  logic [NSRC-1:0] w_ready;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  logic [NSRC-1:0] w_nonempty;
  logic [4:0]      w_in_dest [NSRC];
  logic [31:0]     w_in_val  [NSRC];

  logic [36:0]      r_fifo [NSRC][DEPTH];
  logic [PTR_W-1:0] r_wptr [NSRC];
  logic [PTR_W-1:0] r_rptr [NSRC];
  logic [PTR_W:0]   r_cnt  [NSRC];

  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;

  logic        w_found;
  logic [1:0]  w_gnt_idx;
  logic [36:0] w_head;

  assign w_valid    = {mem_wb_valid, am_wb_valid, mul_wb_valid};
  assign w_writereg = {mem_wb_writereg, am_wb_writereg, mul_wb_writereg};
  assign w_in_dest[SRC_MUL] = mul_wb_regdest;
  assign w_in_dest[SRC_AM]  = am_wb_regdest;
  assign w_in_dest[SRC_MEM] = mem_wb_regdest;
  assign w_in_val[SRC_MUL]  = mul_wb_wbvalue;
  assign w_in_val[SRC_AM]   = am_wb_wbvalue;
  assign w_in_val[SRC_MEM]  = mem_wb_wbvalue;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      // Ready looks only at the count: a full FIFO never accepts, even while popping.
      w_ready[i]    = reset && (r_cnt[i] != FULL_CNT);
      w_nonempty[i] = (r_cnt[i] != '0);
      w_push[i]     = w_valid[i] && w_ready[i] && w_writereg[i];
    end
  end

  assign mul_wb_ready = w_ready[SRC_MUL];
  assign am_wb_ready  = w_ready[SRC_AM];
  assign mem_wb_ready = w_ready[SRC_MEM];
  assign wb_busy      = |w_nonempty;

`ifdef WB_ARB_RR_EN
  logic [1:0] r_rr_last;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    rr_next = (s == SRC_MUL) ? SRC_MEM : (s - 2'd1);
  endfunction

  always_comb begin
    logic [1:0] v_idx;
    w_found   = 1'b0;
    w_gnt_idx = SRC_MUL;
    v_idx     = r_rr_last;
    for (int k = 0; k < NSRC; k++) begin
      v_idx = rr_next(v_idx);
      if (!w_found && w_nonempty[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_last <= SRC_MEM;
    end else if (w_found) begin
      r_rr_last <= w_gnt_idx;
    end
  end
`else
  always_comb begin
    w_found   = 1'b1;
    w_gnt_idx = SRC_MUL;
    if (w_nonempty[SRC_MEM]) begin
      w_gnt_idx = SRC_MEM;
    end else if (w_nonempty[SRC_AM]) begin
      w_gnt_idx = SRC_AM;
    end else if (w_nonempty[SRC_MUL]) begin
      w_gnt_idx = SRC_MUL;
    end else begin
      w_found = 1'b0;
    end
  end
`endif

  always_comb begin
    w_pop = '0;
    if (w_found) begin
      w_pop[w_gnt_idx] = 1'b1;
    end
  end

  assign w_head = r_fifo[w_gnt_idx][r_rptr[w_gnt_idx]];

  // Storage needs no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++) begin
      if (w_push[i]) begin
        r_fifo[i][r_wptr[i]] <= {w_in_dest[i], w_in_val[i]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      r_wb_en <= w_found;
      // Address/data hold when idle; the register file only samples them with wb_reg_en.
      if (w_found) begin
        r_wb_addr <= w_head[36:32];
        r_wb_data <= w_head[31:0];
      end
    end
  end

  assign wb_reg_en   = r_wb_en;
  assign wb_reg_addr = r_wb_addr;
  assign wb_reg_data = r_wb_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter (fixed-priority build).
module tb_wb_port_arbiter;

  logic        clock;
  logic        reset;
  logic        mul_wb_valid, mul_wb_ready, mul_wb_writereg;
  logic [4:0]  mul_wb_regdest;
  logic [31:0] mul_wb_wbvalue;
  logic        am_wb_valid, am_wb_ready, am_wb_writereg;
  logic [4:0]  am_wb_regdest;
  logic [31:0] am_wb_wbvalue;
  logic        mem_wb_valid, mem_wb_ready, mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_wbvalue;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic        wb_busy;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.DEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .mul_wb_valid    (mul_wb_valid),
    .mul_wb_ready    (mul_wb_ready),
    .mul_wb_regdest  (mul_wb_regdest),
    .mul_wb_writereg (mul_wb_writereg),
    .mul_wb_wbvalue  (mul_wb_wbvalue),
    .am_wb_valid     (am_wb_valid),
    .am_wb_ready     (am_wb_ready),
    .am_wb_regdest   (am_wb_regdest),
    .am_wb_writereg  (am_wb_writereg),
    .am_wb_wbvalue   (am_wb_wbvalue),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_ready    (mem_wb_ready),
    .mem_wb_regdest  (mem_wb_regdest),
    .mem_wb_writereg (mem_wb_writereg),
    .mem_wb_wbvalue  (mem_wb_wbvalue),
    .wb_reg_en       (wb_reg_en),
    .wb_reg_addr     (wb_reg_addr),
    .wb_reg_data     (wb_reg_data),
    .wb_busy         (wb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] addr, input logic [31:0] data);
    chk({tag, ".en"}, 64'(wb_reg_en), 64'(en));
    chk({tag, ".addr"}, 64'(wb_reg_addr), 64'(addr));
    chk({tag, ".data"}, 64'(wb_reg_data), 64'(data));
  endtask

  initial begin
    reset = 1'b1;
    mul_wb_valid = 0; mul_wb_writereg = 1; mul_wb_regdest = 0; mul_wb_wbvalue = 0;
    am_wb_valid  = 0; am_wb_writereg  = 1; am_wb_regdest  = 0; am_wb_wbvalue  = 0;
    mem_wb_valid = 0; mem_wb_writereg = 1; mem_wb_regdest = 0; mem_wb_wbvalue = 0;
    #2 reset = 1'b0;
    #1;
    chk_wb("por", 1'b0, 5'd0, 32'd0);
    chk("por.mul_ready", 64'(mul_wb_ready), 64'd0);
    chk("por.mem_ready", 64'(mem_wb_ready), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel.am_ready", 64'(am_wb_ready), 64'd1);
    chk("rel.busy", 64'(wb_busy), 64'd0);

    // Single Mult result: visible the cycle after the edge following the push.
    mul_wb_valid = 1; mul_wb_regdest = 5'd5; mul_wb_wbvalue = 32'hDEADBEEF;
    tick();
    mul_wb_valid = 0;
    chk("t2.busy", 64'(wb_busy), 64'd1);
    chk("t2.en_early", 64'(wb_reg_en), 64'd0);
    tick();
    chk_wb("t2.write", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t2.busy_after", 64'(wb_busy), 64'd0);
    tick();
    chk_wb("t2.idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // Simultaneous completions from all three pipes.
    mem_wb_valid = 1; mem_wb_regdest = 5'd1; mem_wb_wbvalue = 32'h11;
    am_wb_valid  = 1; am_wb_regdest  = 5'd2; am_wb_wbvalue  = 32'h22;
    mul_wb_valid = 1; mul_wb_regdest = 5'd3; mul_wb_wbvalue = 32'h33;
    tick();
    mem_wb_valid = 0; am_wb_valid = 0; mul_wb_valid = 0;
    tick();
    chk_wb("t3.w1", 1'b1, 5'd1, 32'h11);
    tick();
    chk_wb("t3.w2", 1'b1, 5'd2, 32'h22);
    tick();
    chk_wb("t3.w3", 1'b1, 5'd3, 32'h33);
    tick();
    chk("t3.idle", 64'(wb_reg_en), 64'd0);

    // Sustained Mem traffic starves Mult and blocks AluMisc.
    mem_wb_valid = 1; mem_wb_regdest = 5'd8; mem_wb_wbvalue = 32'h80;
    mul_wb_valid = 1; mul_wb_regdest = 5'd4; mul_wb_wbvalue = 32'h44;
    tick();
    chk("t4.mul_ready1", 64'(mul_wb_ready), 64'd1);
    mul_wb_regdest = 5'd5; mul_wb_wbvalue = 32'h45;
    tick();
    mul_wb_valid = 0;
    chk("t4.mul_full", 64'(mul_wb_ready), 64'd0);
    chk_wb("t4.mem_a", 1'b1, 5'd8, 32'h80);
    am_wb_valid = 1; am_wb_regdest = 5'd9; am_wb_wbvalue = 32'h90;
    tick();
    chk_wb("t4.mem_b", 1'b1, 5'd8, 32'h80);
    am_wb_regdest = 5'd10; am_wb_wbvalue = 32'hA0;
    tick();
    chk_wb("t4.mem_c", 1'b1, 5'd8, 32'h80);
    chk("t5.am_full", 64'(am_wb_ready), 64'd0);
    am_wb_regdest = 5'd11; am_wb_wbvalue = 32'hB0;
    tick();
    chk_wb("t4.mem_d", 1'b1, 5'd8, 32'h80);
    chk("t5.am_held", 64'(am_wb_ready), 64'd0);
    chk("t4.mul_starved", 64'(mul_wb_ready), 64'd0);
    mem_wb_valid = 0;
    tick();
    chk_wb("t4.mem_last", 1'b1, 5'd8, 32'h80);
    chk("t5.am_still_full", 64'(am_wb_ready), 64'd0);
    tick();
    chk_wb("t5.am0", 1'b1, 5'd9, 32'h90);
    chk("t5.am_room", 64'(am_wb_ready), 64'd1);
    tick();
    am_wb_valid = 0;
    chk_wb("t5.am1", 1'b1, 5'd10, 32'hA0);
    tick();
    chk_wb("t5.am2", 1'b1, 5'd11, 32'hB0);
    tick();
    chk_wb("t4.mul0", 1'b1, 5'd4, 32'h44);
    tick();
    chk_wb("t4.mul1", 1'b1, 5'd5, 32'h45);
    chk("t4.busy", 64'(wb_busy), 64'd0);
    tick();
    chk("t4.idle", 64'(wb_reg_en), 64'd0);

    // writereg=0: handshake completes, nothing is queued.
    mul_wb_valid = 1; mul_wb_writereg = 0; mul_wb_regdest = 5'd7; mul_wb_wbvalue = 32'h77;
    #1;
    chk("t6.ready", 64'(mul_wb_ready), 64'd1);
    tick();
    mul_wb_valid = 0; mul_wb_writereg = 1;
    chk("t6.busy", 64'(wb_busy), 64'd0);
    tick();
    chk_wb("t6.no_write", 1'b0, 5'd5, 32'h45);

    // Reset while all FIFOs hold entries.
    mem_wb_valid = 1; mem_wb_regdest = 5'd12; mem_wb_wbvalue = 32'hC0;
    am_wb_valid  = 1; am_wb_regdest  = 5'd13; am_wb_wbvalue  = 32'hD0;
    mul_wb_valid = 1; mul_wb_regdest = 5'd14; mul_wb_wbvalue = 32'hE0;
    tick();
    tick();
    mem_wb_valid = 0; am_wb_valid = 0; mul_wb_valid = 0;
    chk("t1.busy_pre", 64'(wb_busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_wb("t1.async", 1'b0, 5'd0, 32'd0);
    chk("t1.rdy_low", 64'({mul_wb_ready, am_wb_ready, mem_wb_ready}), 64'd0);
    tick();
    tick();
    chk_wb("t1.held", 1'b0, 5'd0, 32'd0);
    chk("t1.rdy_low2", 64'({mul_wb_ready, am_wb_ready, mem_wb_ready}), 64'd0);
    reset = 1'b1;
    #1;
    chk("t1.rdy_high", 64'({mul_wb_ready, am_wb_ready, mem_wb_ready}), 64'h7);
    chk("t1.busy_post", 64'(wb_busy), 64'd0);
    tick();
    chk_wb("t1.no_write", 1'b0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
